// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: operation codes, the captured
// result record and the skid-buffer occupancy states.
package alu_pkg;

  localparam int ALU_W = 32;

  localparam logic [2:0] ALU_AND  = 3'b000;
  localparam logic [2:0] ALU_OR   = 3'b001;
  localparam logic [2:0] ALU_ADD  = 3'b010;
  localparam logic [2:0] ALU_XOR  = 3'b011;
  localparam logic [2:0] ALU_NOR  = 3'b100;
  localparam logic [2:0] ALU_RSVD = 3'b101;
  localparam logic [2:0] ALU_SUB  = 3'b110;
  localparam logic [2:0] ALU_SLT  = 3'b111;

  typedef struct packed {
    logic [ALU_W-1:0] result;
    logic             zero;
    logic             ovf;
    logic             illegal;
  } alu_res_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/alu_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; M drives the outputs, S absorbs the
// one extra beat accepted while downstream stalls. in_ready/out_valid are flops.
module alu_skid_buf
  import alu_pkg::*;
#(
  parameter int PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  buf_state_e    state_q, state_d;
  logic [PW-1:0] m_q, m_d;
  logic [PW-1:0] s_q, s_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          in_xfer_s;
  logic          out_xfer_s;

  assign in_xfer_s  = in_valid && in_ready_q;
  assign out_xfer_s = out_valid_q && out_ready;

  // Occupancy transitions and data movement between M and S
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      BUF_EMPTY: begin
        if (in_xfer_s) begin
          m_d     = in_data;
          state_d = BUF_ONE;
        end else begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_ONE: begin
        if (in_xfer_s && !out_xfer_s) begin
          s_d     = in_data;
          state_d = BUF_TWO;
        end else if (in_xfer_s && out_xfer_s) begin
          m_d     = in_data;
        end else if (out_xfer_s) begin
          state_d = BUF_EMPTY;
        end else begin
          state_d = BUF_ONE;
        end
      end
      BUF_TWO: begin
        if (out_xfer_s) begin
          m_d     = s_q;
          state_d = BUF_ONE;
        end else begin
          state_d = BUF_TWO;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    in_ready_d  = (state_d != BUF_TWO);
    out_valid_d = (state_d != BUF_EMPTY);
  end

  // State, payload and handshake registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BUF_EMPTY;
      m_q         <= '0;
      s_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      s_q         <= s_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = m_q;

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: selects a unit output, derives zero/overflow/illegal flags at
// capture, buffers them through a skid buffer and counts accepted overflows.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH     = ALU_W,
  parameter int OVF_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           alu_ctl,
  input  logic [WIDTH-1:0]     and_y,
  input  logic [WIDTH-1:0]     or_y,
  input  logic [WIDTH-1:0]     xor_y,
  input  logic [WIDTH-1:0]     nor_y,
  input  logic [WIDTH-1:0]     add_y,
  input  logic [WIDTH-1:0]     sub_y,
  input  logic                 add_ovf,
  input  logic                 sub_ovf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic                 out_zero,
  output logic                 out_ovf,
  output logic                 out_illegal,
  output logic [OVF_CNT_W-1:0] ovf_count
);

  alu_res_t               res_s;
  alu_res_t               buf_out_s;
  logic                   in_xfer_s;
  logic [OVF_CNT_W-1:0]   ovf_count_q, ovf_count_d;

  // Result select and flag derivation; reserved code yields a zero result
  always_comb begin
    res_s         = '0;
    res_s.illegal = 1'b0;
    case (alu_ctl)
      ALU_AND: res_s.result = and_y;
      ALU_OR:  res_s.result = or_y;
      ALU_XOR: res_s.result = xor_y;
      ALU_NOR: res_s.result = nor_y;
      ALU_ADD: begin
        res_s.result = add_y;
        res_s.ovf    = add_ovf;
      end
      ALU_SUB: begin
        res_s.result = sub_y;
        res_s.ovf    = sub_ovf;
      end
      ALU_SLT: res_s.result = {{(WIDTH-1){1'b0}}, sub_y[WIDTH-1] ^ sub_ovf};
      default: begin
        res_s.result  = '0;
        res_s.illegal = 1'b1;
      end
    endcase
    res_s.zero = (res_s.result == '0);
  end

  assign in_xfer_s = in_valid && in_ready;

  // Saturating overflow counter advanced only on accepted overflowing ops
  always_comb begin
    if (in_xfer_s && res_s.ovf && (ovf_count_q != {OVF_CNT_W{1'b1}})) begin
      ovf_count_d = ovf_count_q + {{(OVF_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      ovf_count_d = ovf_count_q;
    end
  end

  // Overflow counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count_q <= '0;
    end else begin
      ovf_count_q <= ovf_count_d;
    end
  end

  alu_skid_buf #(
    .PW ($bits(alu_res_t))
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (res_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (buf_out_s)
  );

  assign out_result  = buf_out_s.result;
  assign out_zero    = buf_out_s.zero;
  assign out_ovf     = buf_out_s.ovf;
  assign out_illegal = buf_out_s.illegal;
  assign ovf_count   = ovf_count_q;

endmodule
